br_resolve: RTL and testbench

BR_RESOLVE -- requirements
Module: br_resolve

---
 rtl/lc3b_types.sv | 21 ++
 rtl/br_pred_fifo.sv | 58 +++++
 rtl/br_resolve.sv | 122 ++++++++++++
 tb/tb_br_resolve.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_types.sv
// rtl/lc3b_types.sv - LC-3b shared types plus branch-resolve queue entry and FSM state
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [3:0]  lc3b_opcode;

  localparam lc3b_opcode op_br = 4'b0000;

  // One in-flight prediction as captured at fetch
  typedef struct packed {
    lc3b_word pc;
    logic     taken;
    lc3b_word target;
  } br_pred_t;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } br_state_t;

endpackage

// File: rtl/br_pred_fifo.sv
// rtl/br_pred_fifo.sv - in-flight branch prediction queue with synchronous clear
module br_pred_fifo
  import lc3b_types::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     reset_n,
  input  logic     push,
  input  logic     pop,
  input  logic     clear,
  input  br_pred_t wdata,
  output br_pred_t head,
  output logic     full,
  output logic     empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  br_pred_t      mem [DEPTH];

  // Pointer advance with explicit wrap so non-power-of-two depths stay correct
  function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // Pointer and occupancy tracking; clear wins over any same-cycle push/pop
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wrap_inc(wr_ptr);
      if (pop)  rd_ptr <= wrap_inc(rd_ptr);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // Entry storage; a full push+pop overwrites the slot whose old value is read this cycle
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/br_resolve.sv
// rtl/br_resolve.sv - WB-stage branch resolution: compare, redirect, flush and predictor update
module br_resolve
  import lc3b_types::*;
#(
  parameter int DEPTH        = 4,
  parameter int FLUSH_CYCLES = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pred_valid,
  input  logic [15:0] pred_pc,
  input  logic        pred_taken,
  input  logic [15:0] pred_target,
  output logic        fetch_stall,
  input  logic        res_valid,
  input  logic [3:0]  opcode_wb,
  input  logic [15:0] pc_wb,
  input  logic        actual_taken,
  input  logic [15:0] actual_target,
  output logic        flush,
  output logic        redirect_valid,
  output logic [15:0] redirect_pc,
  output logic        upd_valid,
  output logic [15:0] upd_pc,
  output logic [15:0] upd_target,
  output logic        res_err,
  output logic [15:0] br_count,
  output logic [15:0] mp_count
);

  localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FW-1:0] FLUSH_LOAD = FW'(FLUSH_CYCLES - 1);

  br_state_t state, state_next;
  logic [FW-1:0] fcnt, fcnt_next;

  br_pred_t head;
  br_pred_t wdata;
  logic     full, empty;
  logic     run, resolve, pop, push, mispredict;

  assign wdata = '{pc: pred_pc, taken: pred_taken, target: pred_target};

  assign run        = (state == ST_RUN);
  assign resolve    = res_valid && (opcode_wb == op_br) && run;
  assign pop        = resolve && !empty;
  assign push       = pred_valid && run && (!full || pop);
  assign mispredict = pop && ((head.pc != pc_wb) || (head.taken != actual_taken) ||
                              (actual_taken && (head.target != actual_target)));

  assign fetch_stall = full;

  br_pred_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .clear   (mispredict),
    .wdata   (wdata),
    .head    (head),
    .full    (full),
    .empty   (empty)
  );

  // FSM state and flush countdown registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_RUN;
      fcnt  <= '0;
    end else begin
      state <= state_next;
      fcnt  <= fcnt_next;
    end
  end

  // Next state: mispredict enters FLUSH, which stays until the cycle the counter reads zero
  always_comb begin
    state_next = state;
    fcnt_next  = fcnt;
    case (state)
      ST_RUN: begin
        if (mispredict) begin
          state_next = ST_FLUSH;
          fcnt_next  = FLUSH_LOAD;
        end
      end
      ST_FLUSH: begin
        if (fcnt == '0) state_next = ST_RUN;
        else            fcnt_next  = fcnt - FW'(1);
      end
      default: state_next = ST_RUN;
    endcase
  end

  // Registered outputs, one cycle after the resolving cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flush          <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      upd_valid      <= 1'b0;
      upd_pc         <= '0;
      upd_target     <= '0;
      res_err        <= 1'b0;
      br_count       <= '0;
      mp_count       <= '0;
    end else begin
      flush          <= (state_next == ST_FLUSH);
      redirect_valid <= mispredict;
      if (mispredict) redirect_pc <= actual_taken ? actual_target : pc_wb + 16'd2;
      upd_valid      <= pop && actual_taken;
      if (pop && actual_taken) begin
        upd_pc     <= pc_wb;
        upd_target <= actual_target;
      end
      res_err <= resolve && empty;
      if (pop && (br_count != 16'hFFFF))        br_count <= br_count + 16'd1;
      if (mispredict && (mp_count != 16'hFFFF)) mp_count <= mp_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_br_resolve.sv
// tb/tb_br_resolve.sv - self-checking bench for br_resolve against a queue-based reference model
module tb_br_resolve;

  localparam int DEPTH = 4;
  localparam int FC    = 3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        pred_valid = 1'b0;
  logic [15:0] pred_pc = '0;
  logic        pred_taken = 1'b0;
  logic [15:0] pred_target = '0;
  logic        fetch_stall;
  logic        res_valid = 1'b0;
  logic [3:0]  opcode_wb = '0;
  logic [15:0] pc_wb = '0;
  logic        actual_taken = 1'b0;
  logic [15:0] actual_target = '0;
  logic        flush, redirect_valid, upd_valid, res_err;
  logic [15:0] redirect_pc, upd_pc, upd_target, br_count, mp_count;

  always #5 clk = ~clk;

  br_resolve #(.DEPTH(DEPTH), .FLUSH_CYCLES(FC)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .pred_valid     (pred_valid),
    .pred_pc        (pred_pc),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .fetch_stall    (fetch_stall),
    .res_valid      (res_valid),
    .opcode_wb      (opcode_wb),
    .pc_wb          (pc_wb),
    .actual_taken   (actual_taken),
    .actual_target  (actual_target),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_target     (upd_target),
    .res_err        (res_err),
    .br_count       (br_count),
    .mp_count       (mp_count)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] pc;
    logic        tk;
    logic [15:0] tg;
  } ent_t;

  ent_t        q[$];
  int          flush_left;
  int          m_br, m_mp;
  logic        e_flush, e_rv, e_uv, e_err;
  logic [15:0] e_rpc, e_upc, e_utg;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    flush_left = 0;
    m_br = 0;
    m_mp = 0;
  endtask

  task automatic step(input logic pv, input logic [15:0] ppc, input logic pt, input logic [15:0] ptg,
                      input logic rv, input logic [3:0] op, input logic [15:0] pcw,
                      input logic at, input logic [15:0] atg);
    ent_t h;
    bit   run, do_pop, mp;
    int   sz;
    pred_valid = pv; pred_pc = ppc; pred_taken = pt; pred_target = ptg;
    res_valid = rv; opcode_wb = op; pc_wb = pcw; actual_taken = at; actual_target = atg;
    #1;
    sz = q.size();
    chk("fetch_stall", {31'd0, fetch_stall}, {31'd0, sz == DEPTH});
    run = (flush_left == 0);
    e_err = 1'b0; e_uv = 1'b0; e_rv = 1'b0; mp = 0; do_pop = 0;
    if (rv && op == 4'b0000 && run) begin
      if (sz == 0) begin
        e_err = 1'b1;
      end else begin
        do_pop = 1;
        h = q.pop_front();
        if (m_br < 65535) m_br++;
        mp = (h.pc != pcw) || (h.tk != at) || (at && h.tg != atg);
        if (at) begin
          e_uv = 1'b1; e_upc = pcw; e_utg = atg;
        end
        if (mp) begin
          if (m_mp < 65535) m_mp++;
          e_rv = 1'b1;
          e_rpc = at ? atg : 16'(pcw + 16'd2);
        end
      end
    end
    if (pv && run && (sz < DEPTH || do_pop)) q.push_back('{ppc, pt, ptg});
    if (mp) begin
      q.delete();
      flush_left = FC;
    end else if (flush_left > 0) begin
      flush_left--;
    end
    e_flush = (flush_left > 0);
    @(posedge clk);
    #1;
    chk("flush", {31'd0, flush}, {31'd0, e_flush});
    chk("redirect_valid", {31'd0, redirect_valid}, {31'd0, e_rv});
    if (e_rv) chk("redirect_pc", {16'd0, redirect_pc}, {16'd0, e_rpc});
    chk("upd_valid", {31'd0, upd_valid}, {31'd0, e_uv});
    if (e_uv) begin
      chk("upd_pc", {16'd0, upd_pc}, {16'd0, e_upc});
      chk("upd_target", {16'd0, upd_target}, {16'd0, e_utg});
    end
    chk("res_err", {31'd0, res_err}, {31'd0, e_err});
    chk("br_count", {16'd0, br_count}, 32'(m_br));
    chk("mp_count", {16'd0, mp_count}, 32'(m_mp));
  endtask

  task automatic idle();
    step(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 4'h0, 16'h0, 1'b0, 16'h0);
  endtask

  task automatic push(input logic [15:0] pc, input logic tk, input logic [15:0] tg);
    step(1'b1, pc, tk, tg, 1'b0, 4'h0, 16'h0, 1'b0, 16'h0);
  endtask

  task automatic resolve(input logic [15:0] pc, input logic tk, input logic [15:0] tg);
    step(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 4'h0, pc, tk, tg);
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
    chk("rst_redirect_pc", {16'd0, redirect_pc}, 32'd0);
    chk("rst_upd_valid", {31'd0, upd_valid}, 32'd0);
    chk("rst_upd_pc", {16'd0, upd_pc}, 32'd0);
    chk("rst_upd_target", {16'd0, upd_target}, 32'd0);
    chk("rst_res_err", {31'd0, res_err}, 32'd0);
    chk("rst_br_count", {16'd0, br_count}, 32'd0);
    chk("rst_mp_count", {16'd0, mp_count}, 32'd0);
    chk("rst_fetch_stall", {31'd0, fetch_stall}, 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
  endtask

  initial begin
    logic        pv, pt, rv, at;
    logic [15:0] ppc, ptg, pcw, atg;
    logic [3:0]  op;
    int          r;

    model_reset();
    #2;
    apply_reset();

    // correctly predicted taken branch updates the predictor
    push(16'h3000, 1'b1, 16'h3010);
    resolve(16'h3000, 1'b1, 16'h3010);
    chk("d1_upd_valid", {31'd0, upd_valid}, 32'd1);
    chk("d1_upd_pc", {16'd0, upd_pc}, 32'h3000);
    chk("d1_upd_target", {16'd0, upd_target}, 32'h3010);
    chk("d1_flush", {31'd0, flush}, 32'd0);
    chk("d1_br_count", {16'd0, br_count}, 32'd1);

    // predicted not-taken, actually taken: redirect to target, three flush cycles
    push(16'h3000, 1'b0, 16'h0000);
    resolve(16'h3000, 1'b1, 16'h3020);
    chk("d2_redirect_pc", {16'd0, redirect_pc}, 32'h3020);
    chk("d2_mp_count", {16'd0, mp_count}, 32'd1);
    chk("d2_flush1", {31'd0, flush}, 32'd1);
    idle();
    chk("d2_flush2", {31'd0, flush}, 32'd1);
    idle();
    chk("d2_flush3", {31'd0, flush}, 32'd1);
    idle();
    chk("d2_flush_end", {31'd0, flush}, 32'd0);
    resolve(16'h1234, 1'b0, 16'h0);
    chk("d2_empty_err", {31'd0, res_err}, 32'd1);
    chk("d2_br_unchanged", {16'd0, br_count}, 32'd2);

    // predicted taken, actually not taken: fall-through redirect
    push(16'h30FE, 1'b1, 16'h3100);
    resolve(16'h30FE, 1'b0, 16'h0000);
    chk("d3_redirect_pc", {16'd0, redirect_pc}, 32'h3100);
    chk("d3_upd_valid", {31'd0, upd_valid}, 32'd0);
    idle(); idle(); idle();

    // non-BR opcode at WB is ignored
    push(16'h4000, 1'b0, 16'h0);
    step(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 4'b0001, 16'h9999, 1'b1, 16'h8888);
    resolve(16'h4000, 1'b0, 16'h0);
    chk("d4_mp_count", {16'd0, mp_count}, 32'd2);

    // fill, push+pop while full, then drain in order
    for (int i = 0; i < DEPTH; i++) push(16'h5000 + 16'(2 * i), 1'(i % 2), 16'h6000 + 16'(i));
    chk("d5_full_stall", {31'd0, fetch_stall}, 32'd1);
    step(1'b1, 16'h5008, 1'b1, 16'h6004, 1'b1, 4'h0, 16'h5000, 1'b0, 16'h0);
    chk("d5_still_full", {31'd0, fetch_stall}, 32'd1);
    resolve(16'h5002, 1'b1, 16'h6001);
    resolve(16'h5004, 1'b0, 16'h0);
    resolve(16'h5006, 1'b1, 16'h6003);
    resolve(16'h5008, 1'b1, 16'h6004);
    chk("d5_no_mp", {16'd0, mp_count}, 32'd2);
    chk("d5_drained", {31'd0, fetch_stall}, 32'd0);

    // pushes during flush are dropped
    push(16'h7000, 1'b0, 16'h0);
    resolve(16'h7002, 1'b0, 16'h0);
    push(16'h7100, 1'b0, 16'h0);
    push(16'h7102, 1'b0, 16'h0);
    push(16'h7104, 1'b0, 16'h0);
    resolve(16'h7100, 1'b0, 16'h0);
    chk("d6_dropped_err", {31'd0, res_err}, 32'd1);

    // reset in the second flush cycle aborts the flush
    push(16'h7200, 1'b1, 16'h7300);
    resolve(16'h7200, 1'b1, 16'h7400);
    idle();
    apply_reset();
    resolve(16'h7200, 1'b0, 16'h0);
    chk("d7_run_err", {31'd0, res_err}, 32'd1);
    chk("d7_br_zero", {16'd0, br_count}, 32'd0);

    // randomized traffic, resolves usually aimed at the model's head entry
    for (int n = 0; n < 400; n++) begin
      pv  = 1'($urandom_range(0, 1));
      ppc = 16'($urandom) & 16'hFFFE;
      pt  = 1'($urandom_range(0, 1));
      ptg = 16'($urandom);
      rv  = ($urandom_range(0, 9) < 6);
      op  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
      pcw = 16'($urandom);
      at  = 1'($urandom_range(0, 1));
      atg = 16'($urandom);
      if (q.size() > 0 && $urandom_range(0, 3) != 0) begin
        pcw = q[0].pc;
        at  = q[0].tk;
        atg = q[0].tg;
        r = $urandom_range(0, 9);
        if (r == 0) at  = ~at;
        if (r == 1) pcw = pcw + 16'd2;
        if (r == 2) atg = atg ^ 16'h0010;
      end
      step(pv, ppc, pt, ptg, rv, op, pcw, at, atg);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
